// File: rtl/pipeline_pkg.sv
// Shared ID-stage definitions: opcodes, funct codes, ALU op encoding,
// id_ex_ctrl bit positions and the control decoder.
package pipeline_pkg;

  localparam int unsigned AddrWDefault = 11;
  localparam int unsigned DataWDefault = 32;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b100
  } alu_op_e;

  localparam int unsigned CtrlW        = 9;
  localparam int unsigned CtrlRegDst   = 8;
  localparam int unsigned CtrlAluSrc   = 7;
  localparam int unsigned CtrlAluOpHi  = 6;
  localparam int unsigned CtrlAluOpLo  = 4;
  localparam int unsigned CtrlMemRead  = 3;
  localparam int unsigned CtrlMemWrite = 2;
  localparam int unsigned CtrlRegWrite = 1;
  localparam int unsigned CtrlMemToReg = 0;

  // Branches, jumps and anything unrecognised carry no EX work: all-zero control.
  function automatic logic [CtrlW-1:0] decode_ctrl(input logic [5:0] opcode,
                                                   input logic [5:0] funct);
    logic [CtrlW-1:0] c;
    c = '0;
    case (opcode)
      OpRtype: begin
        c[CtrlRegDst]   = 1'b1;
        c[CtrlRegWrite] = 1'b1;
        case (funct)
          FnAdd:   c[CtrlAluOpHi:CtrlAluOpLo] = AluAdd;
          FnSub:   c[CtrlAluOpHi:CtrlAluOpLo] = AluSub;
          FnAnd:   c[CtrlAluOpHi:CtrlAluOpLo] = AluAnd;
          FnOr:    c[CtrlAluOpHi:CtrlAluOpLo] = AluOr;
          FnSlt:   c[CtrlAluOpHi:CtrlAluOpLo] = AluSlt;
          default: c = '0;
        endcase
      end
      OpLw: begin
        c[CtrlAluSrc]   = 1'b1;
        c[CtrlMemRead]  = 1'b1;
        c[CtrlRegWrite] = 1'b1;
        c[CtrlMemToReg] = 1'b1;
      end
      OpSw: begin
        c[CtrlAluSrc]   = 1'b1;
        c[CtrlMemWrite] = 1'b1;
      end
      OpAddi: begin
        c[CtrlAluSrc]   = 1'b1;
        c[CtrlRegWrite] = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file, two combinational read ports, one write port, $0 hardwired.
// REGFILE_BYPASS_EN: a same-cycle write is forwarded to the read ports.
module reg_file import pipeline_pkg::*; #(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned NREG   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        read_addr_1,
  input  logic [4:0]        read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              write_en,
  input  logic [4:0]        write_addr,
  input  logic [DATA_W-1:0] write_data
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_en && (write_addr != 5'd0)) begin
      regs_q[write_addr] <= write_data;
    end
  end

  always_comb begin
    read_data_1 = (read_addr_1 == 5'd0) ? '0 : regs_q[read_addr_1];
    read_data_2 = (read_addr_2 == 5'd0) ? '0 : regs_q[read_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (write_en && (write_addr != 5'd0) && (write_addr == read_addr_1)) begin
      read_data_1 = write_data;
    end
    if (write_en && (write_addr != 5'd0) && (write_addr == read_addr_2)) begin
      read_data_2 = write_data;
    end
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode, register read, branch/jump resolution, hazard detection, ID/EX register.
// Build option REGFILE_BYPASS_EN enables write-before-read forwarding in reg_file.
module instruction_decode import pipeline_pkg::*; #(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned NREG   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruccion,
  input  logic [ADDR_W-1:0] pc,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_mem_read,
  input  logic [4:0]        ex_mem_rd,
  output logic [ADDR_W-1:0] pc_salto,
  output logic              salto_sel,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_flush,
  output logic [CtrlW-1:0]  id_ex_ctrl,
  output logic [DATA_W-1:0] id_ex_read_data_1,
  output logic [DATA_W-1:0] id_ex_read_data_2,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm_ext;
  logic [CtrlW-1:0]  ctrl_dec;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              is_beq;
  logic              is_bne;
  logic              is_j;
  logic              is_branch;
  logic              uses_rt;
  logic [4:0]        id_ex_dest;
  logic              load_use;
  logic              branch_hazard;
  logic              stall;
  logic              taken;

  logic [CtrlW-1:0]  ctrl_q;
  logic [DATA_W-1:0] read_data_1_q;
  logic [DATA_W-1:0] read_data_2_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;

  assign opcode   = instruccion[31:26];
  assign rs       = instruccion[25:21];
  assign rt       = instruccion[20:16];
  assign rd       = instruccion[15:11];
  assign funct    = instruccion[5:0];
  assign imm_ext  = {{(DATA_W-16){instruccion[15]}}, instruccion[15:0]};
  assign ctrl_dec = decode_ctrl(opcode, funct);

  reg_file #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_reg_file (
    .clock       (clock),
    .reset       (reset),
    .read_addr_1 (rs),
    .read_addr_2 (rt),
    .read_data_1 (rs_data),
    .read_data_2 (rt_data),
    .write_en    (wb_reg_write),
    .write_addr  (wb_rd),
    .write_data  (wb_data)
  );

  always_comb begin
    is_beq    = (opcode == OpBeq);
    is_bne    = (opcode == OpBne);
    is_j      = (opcode == OpJ);
    is_branch = is_beq || is_bne;
    uses_rt   = (opcode == OpRtype) || is_branch || (opcode == OpSw);
    id_ex_dest = id_ex_ctrl[CtrlRegDst] ? id_ex_rd : id_ex_rt;

    load_use = id_ex_ctrl[CtrlMemRead] && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));

    // The comparator sits in ID, so any producer still in EX or a load in MEM must wait.
    branch_hazard = is_branch &&
                    ((id_ex_ctrl[CtrlRegWrite] && (id_ex_dest != 5'd0) &&
                      ((id_ex_dest == rs) || (id_ex_dest == rt))) ||
                     (ex_mem_mem_read && (ex_mem_rd != 5'd0) &&
                      ((ex_mem_rd == rs) || (ex_mem_rd == rt))));

    stall = !reset && (load_use || branch_hazard);
    taken = !reset && !stall &&
            ((is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data)) || is_j);

    pc_salto    = is_j ? instruccion[ADDR_W-1:0] : pc + instruccion[ADDR_W-1:0];
    salto_sel   = taken;
    if_flush    = taken;
    pc_write    = !stall;
    if_id_write = !stall;
  end

  always_ff @(posedge clock) begin
    if (reset || stall) begin
      ctrl_q        <= '0;
      read_data_1_q <= '0;
      read_data_2_q <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
    end else begin
      ctrl_q        <= ctrl_dec;
      read_data_1_q <= rs_data;
      read_data_2_q <= rt_data;
      imm_q         <= imm_ext;
      rs_q          <= rs;
      rt_q          <= rt;
      rd_q          <= rd;
    end
  end

  assign id_ex_ctrl        = ctrl_q;
  assign id_ex_read_data_1 = read_data_1_q;
  assign id_ex_read_data_2 = read_data_2_q;
  assign id_ex_imm         = imm_q;
  assign id_ex_rs          = rs_q;
  assign id_ex_rt          = rt_q;
  assign id_ex_rd          = rd_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed stimulus queues expectations tagged
// with the cycle they are due; a negedge monitor pops and compares them.
module tb_instruction_decode;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  localparam int KPcWrite = 0, KIfIdWrite = 1, KIfFlush = 2, KSaltoSel = 3, KPcSalto = 4;
  localparam int KCtrl = 5, KRd1 = 6, KRd2 = 7, KImm = 8, KRs = 9, KRt = 10, KRd = 11;

  localparam logic [31:0] CtrlAdd  = 32'h102;
  localparam logic [31:0] CtrlLw   = 32'h08B;
  localparam logic [31:0] CtrlAddi = 32'h082;

  logic              clock;
  logic              reset;
  logic [31:0]       instruccion;
  logic [ADDR_W-1:0] pc;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_mem_mem_read;
  logic [4:0]        ex_mem_rd;
  logic [ADDR_W-1:0] pc_salto;
  logic              salto_sel;
  logic              pc_write;
  logic              if_id_write;
  logic              if_flush;
  logic [8:0]        id_ex_ctrl;
  logic [DATA_W-1:0] id_ex_read_data_1;
  logic [DATA_W-1:0] id_ex_read_data_2;
  logic [DATA_W-1:0] id_ex_imm;
  logic [4:0]        id_ex_rs;
  logic [4:0]        id_ex_rt;
  logic [4:0]        id_ex_rd;

  instruction_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NREG   (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .instruccion       (instruccion),
    .pc                (pc),
    .wb_reg_write      (wb_reg_write),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_rd         (ex_mem_rd),
    .pc_salto          (pc_salto),
    .salto_sel         (salto_sel),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .if_flush          (if_flush),
    .id_ex_ctrl        (id_ex_ctrl),
    .id_ex_read_data_1 (id_ex_read_data_1),
    .id_ex_read_data_2 (id_ex_read_data_2),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rs          (id_ex_rs),
    .id_ex_rt          (id_ex_rt),
    .id_ex_rd          (id_ex_rd)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int k);
    case (k)
      KPcWrite:   return 32'(pc_write);
      KIfIdWrite: return 32'(if_id_write);
      KIfFlush:   return 32'(if_flush);
      KSaltoSel:  return 32'(salto_sel);
      KPcSalto:   return 32'(pc_salto);
      KCtrl:      return 32'(id_ex_ctrl);
      KRd1:       return id_ex_read_data_1;
      KRd2:       return id_ex_read_data_2;
      KImm:       return id_ex_imm;
      KRs:        return 32'(id_ex_rs);
      KRt:        return 32'(id_ex_rt);
      KRd:        return 32'(id_ex_rd);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: everything due this cycle is compared; anything overdue is a failure too.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = actual(mon_e.kind);
      checks++;
      if (mon_e.cyc < cyc || mon_act !== mon_e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", mon_e.name, mon_e.cyc,
                 mon_act, mon_e.val);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int d, input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic put_hz(input bit stalled, input bit redirect, input string n);
    put(0, KPcWrite,   32'(!stalled), {n, ".pc_write"});
    put(0, KIfIdWrite, 32'(!stalled), {n, ".if_id_write"});
    put(0, KSaltoSel,  32'(redirect), {n, ".salto_sel"});
    put(0, KIfFlush,   32'(redirect), {n, ".if_flush"});
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_reg_write = we;
    wb_rd        = r;
    wb_data      = d;
  endtask

  logic [5:0]  fn_tab  [5] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
  logic [31:0] fn_ctrl [5] = '{32'h112, 32'h122, 32'h132, 32'h142, 32'h000};

  initial begin
    reset = 1'b1; instruccion = '0; pc = '0;
    wb(1'b0, 5'd0, '0);
    ex_mem_mem_read = 1'b0; ex_mem_rd = '0;

    step(); put_hz(0, 0, "rst1");
    step(); put_hz(0, 0, "rst2");

    // Release; add $3,$5,$5 reads the cleared $5.
    step(); reset = 1'b0; instruccion = 32'h00A51820;
    put_hz(0, 0, "rel");
    put(0, KCtrl, 0, "rst.ctrl"); put(0, KRd1, 0, "rst.rd1"); put(0, KImm, 0, "rst.imm");
    put(0, KRd, 0, "rst.rd");
    put(1, KCtrl, CtrlAdd, "rd5.ctrl"); put(1, KRd1, 0, "rd5.rd1"); put(1, KRd2, 0, "rd5.rd2");

    step(); instruccion = '0; wb(1'b1, 5'd1, 32'd7);
    step(); wb(1'b1, 5'd2, 32'd5);

    // add $3,$1,$2
    step(); wb(1'b0, 5'd0, '0); instruccion = 32'h00221820;
    put_hz(0, 0, "add");
    put(1, KRd1, 7, "add.rd1"); put(1, KRd2, 5, "add.rd2"); put(1, KCtrl, CtrlAdd, "add.ctrl");
    put(1, KRd, 3, "add.rd"); put(1, KRs, 1, "add.rs"); put(1, KRt, 2, "add.rt");
    put(1, KImm, 32'h1820, "add.imm");

    // lw $4,0($1) then dependent add $5,$4,$2
    step(); instruccion = 32'h8C240000;
    put_hz(0, 0, "lw");
    put(1, KCtrl, CtrlLw, "lw.ctrl"); put(1, KRt, 4, "lw.rt");
    step(); instruccion = 32'h00822820;
    put_hz(1, 0, "lu");
    put(1, KCtrl, 0, "lu.bub.ctrl"); put(1, KRt, 0, "lu.bub.rt"); put(1, KRd, 0, "lu.bub.rd");
    step();
    put_hz(0, 0, "lu.go");
    put(1, KCtrl, CtrlAdd, "lu.go.ctrl"); put(1, KRd, 5, "lu.go.rd");
    put(1, KRd1, 0, "lu.go.rd1"); put(1, KRd2, 5, "lu.go.rd2");

    step(); instruccion = '0; wb(1'b1, 5'd1, 32'd9);
    step(); wb(1'b1, 5'd2, 32'd9);

    // Branches and jump
    step(); wb(1'b0, 5'd0, '0); instruccion = 32'h10220003; pc = 11'h010;
    put_hz(0, 1, "beq"); put(0, KPcSalto, 32'h013, "beq.tgt");
    put(1, KCtrl, 0, "beq.ctrl"); put(1, KRs, 1, "beq.rs");
    step(); instruccion = 32'h10220002; pc = 11'h7FF;
    put_hz(0, 1, "beq.wrap"); put(0, KPcSalto, 32'h001, "beq.wrap.tgt");
    step(); instruccion = 32'h14220002; pc = 11'h020;
    put_hz(0, 0, "bne.nt");
    step(); instruccion = 32'h08000155; pc = 11'h030;
    put_hz(0, 1, "j"); put(0, KPcSalto, 32'h155, "j.tgt");
    step(); instruccion = 32'h1022FFFC; pc = 11'h003;
    put_hz(0, 1, "beq.neg"); put(0, KPcSalto, 32'h7FF, "beq.neg.tgt");
    put(1, KImm, 32'hFFFF_FFFC, "beq.neg.imm");

    // addi $1 in ID/EX while beq $1,$2 sits in ID
    step(); instruccion = 32'h20010004; pc = 11'h040;
    put_hz(0, 0, "addi");
    put(1, KCtrl, CtrlAddi, "addi.ctrl"); put(1, KRt, 1, "addi.rt"); put(1, KImm, 4, "addi.imm");
    step(); instruccion = 32'h10220003; pc = 11'h041;
    put_hz(1, 0, "bhaz");
    put(1, KCtrl, 0, "bhaz.bub.ctrl"); put(1, KRt, 0, "bhaz.bub.rt");
    step();
    put_hz(0, 1, "bhaz.go"); put(0, KPcSalto, 32'h044, "bhaz.go.tgt");

    // Load in MEM feeding a branch
    step(); instruccion = 32'h14220002; pc = 11'h050; ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd2;
    put_hz(1, 0, "exmem");
    step(); ex_mem_rd = 5'd0;
    put_hz(0, 0, "exmem.r0");

    // $0 write ignored; same-cycle write visibility
    step(); ex_mem_mem_read = 1'b0; instruccion = '0; wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    step(); wb(1'b0, 5'd0, '0); instruccion = 32'h00003820;
    put(1, KRd1, 0, "r0.rd1"); put(1, KRd2, 0, "r0.rd2");
    step(); wb(1'b1, 5'd6, 32'hAB); instruccion = 32'h00C04020;
`ifdef REGFILE_BYPASS_EN
    put(1, KRd1, 32'hAB, "byp.rd1");
`else
    put(1, KRd1, 32'h0, "byp.rd1");
`endif
    step(); wb(1'b0, 5'd0, '0);
    put(1, KRd1, 32'hAB, "r6.rd1");

    // Reset arriving during a load-use stall
    step(); instruccion = 32'h8C240000;
    put(1, KCtrl, CtrlLw, "lw2.ctrl");
    step(); reset = 1'b1; instruccion = 32'h00822820;
    put_hz(0, 0, "rst.stall");
    put(1, KCtrl, 0, "rst.stall.ctrl");
    step(); reset = 1'b0;
    put_hz(0, 0, "post.rst");
    put(1, KCtrl, CtrlAdd, "post.rst.ctrl"); put(1, KRd2, 0, "post.rst.rd2");

    for (int i = 0; i < 5; i++) begin
      step(); instruccion = 32'h00221800 | 32'(fn_tab[i]);
      put(1, KCtrl, fn_ctrl[i], $sformatf("fn%02h.ctrl", fn_tab[i]));
    end
    step(); instruccion = 32'hFC000000;
    put(1, KCtrl, 0, "badop.ctrl");

    step(); instruccion = '0;
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- ID stage of the 5-stage pipeline; consumes the IF/ID outputs `instruccion[31:0]` and `pc[10:0]`, which is pc+1.
- Decodes the instruction and reads the register file.
- Resolves beq/bne/j in ID and drives `pc_salto`/`salto_sel` back to fetch.
- Detects load-use and branch hazards, driving `pc_write`/`if_id_write`/`if_flush`.
- Registers operands and control into the ID/EX pipeline register.

Parameters:
- ADDR_W, 11, instruction-memory word-address width (width of pc and pc_salto).
- DATA_W, 32, register and immediate width.
- NREG, 32, register-file depth; fixed by 5-bit register fields.

Ports:
- clock  in  1  rising-edge clock, the single clock domain.
- reset  in  1  synchronous, active-high.
- instruccion  in  32  IF/ID instruction.
- pc  in  ADDR_W  IF/ID pc+1.
- wb_reg_write  in  1  WB write enable.
- wb_rd  in  5  WB destination register.
- wb_data  in  DATA_W  WB data.
- ex_mem_mem_read  in  1  instruction now in MEM is a load.
- ex_mem_rd  in  5  its destination register.
- pc_salto  out  ADDR_W  branch/jump target.
- salto_sel  out  1  1 = fetch takes pc_salto.
- pc_write  out  1  0 = hold PC.
- if_id_write  out  1  0 = hold IF/ID.
- if_flush  out  1  1 = IF/ID loads a nop (all zeros).
- id_ex_ctrl  out  9  control bits: [8]reg_dst [7]alu_src [6:4]alu_op [3]mem_read [2]mem_write [1]reg_write [0]mem_to_reg.
- id_ex_read_data_1, id_ex_read_data_2  out  DATA_W  rs and rt operand values.
- id_ex_imm  out  DATA_W  sign-extended instr[15:0].
- id_ex_rs, id_ex_rt, id_ex_rd  out  5  register fields.

Behaviour:
- Decoded opcodes:
  - 0x00 R-type, funct 0x20 add / 0x22 sub / 0x24 and / 0x25 or / 0x2A slt.
  - 0x23 lw, 0x2B sw, 0x08 addi, 0x04 beq, 0x05 bne, 0x02 j.
  - Anything else, including unknown funct, decodes to all-zero control (nop).
- alu_op encoding: 000 add, 001 sub, 010 and, 011 or, 100 slt.
  - lw, sw and addi use add with alu_src=1.
- Register file:
  - 32x32; $0 reads 0 and writes to it are ignored.
  - Write occurs on clock edge when wb_reg_write=1.
  - Reads are combinational.
  - Without the optional feature, a same-cycle write is NOT visible to the read.
- Load-use stall condition: id_ex_ctrl.mem_read=1 and id_ex_rt!=0 and id_ex_rt equals the current rs, or the current rt for R-type/beq/bne/sw.
- Branch stall condition: current op is beq/bne, and either:
  - (id_ex reg_write=1 and the ID/EX destination is rs or rt, nonzero), or
  - (ex_mem_mem_read=1 and ex_mem_rd is rs or rt, nonzero).
  - ID/EX destination = id_ex_rd when reg_dst=1, else id_ex_rt.
- On stall (combinational): pc_write=0, if_id_write=0, salto_sel=0, if_flush=0; next edge loads a bubble (all id_ex outputs 0).
- No stall: pc_write=1, if_id_write=1; next edge loads decoded control, operands, imm and fields.
- Branch/jump resolution (combinational, no stall only):
  - beq taken if rs==rt; bne taken if rs!=rt.
  - Branch target = pc + imm[10:0], modulo 2^ADDR_W (wraps, no overflow flag).
  - j target = instr[10:0].
  - Taken branch or j: salto_sel=1, if_flush=1.
  - Not taken: salto_sel=0, if_flush=0, pc_salto = branch target (don't-care).
- beq, bne and j enter ID/EX as nop control; they have no EX work.
- Latency:
  - ID/EX outputs: 1 cycle.
  - pc_salto/salto_sel: 0 cycles (combinational from IF/ID).
  - Redirect penalty: 1 flushed slot.
- Reset (synchronous):
  - All id_ex outputs and all registers go to 0.
  - Hazard outputs during reset: pc_write=1, if_id_write=1, salto_sel=0, if_flush=0.
  - Reset mid-stall drops the stall; the bubble is not retained.
- Simultaneous events: a stall always overrides a branch/jump redirect. An all-zero instruccion (a flushed slot) decodes as a nop and never stalls.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-before-read bypass. A read of register r returns wb_data when wb_reg_write=1, wb_rd==r and r!=0. This applies to both the ID/EX operands and the branch comparator.
- Not defined: reads return the pre-write stored value; WB-to-ID dependencies must be separated by the compiler.

Decomposition:
- Shared package `pipeline_pkg` holds:
  - opcode and funct constants;
  - alu_op encodings;
  - id_ex_ctrl bit-index constants;
  - ADDR_W and DATA_W defaults.
- One natural sub-module: `reg_file` (32x32, 2 read ports, 1 write port, $0 hardwired, bypass under the macro).
- Decode logic, hazard logic and the ID/EX register stay in the top.

Test Plan:
- Reset: reset=1 for 2 cycles, then release -> all id_ex outputs 0, pc_write=1, salto_sel=0; reading $5 returns 0.
- ALU decode:
  - Setup: WB writes $1=7 and $2=5, then ID sees add $3,$1,$2 (0x00221820).
  - Next cycle: read_data_1=7, read_data_2=5, id_ex_ctrl reg_dst=1, alu_op=000, reg_write=1, id_ex_rd=3.
- Load-use:
  - lw $4,0($1) enters ID/EX; ID holds add $5,$4,$2.
  - Expect pc_write=0 and if_id_write=0 for 1 cycle, bubble ctrl=0, then add proceeds.
- Taken branch: $1=$2=9, beq $1,$2,+3 with pc=0x010 -> salto_sel=1, pc_salto=0x013, if_flush=1. With pc=0x7FF and imm=+2, pc_salto=0x001.
- Branch hazard versus redirect:
  - ID/EX holds addi $1 (reg_write=1, rt=1); ID holds beq $1,$2.
  - Expect a stall with salto_sel=0, then resolve the next cycle.
- Write to $0 and bypass: WB writes $0=0xFFFF_FFFF -> reads of $0 return 0. Same-cycle WB $6=0xAB with a read of $6 -> 0xAB only with REGFILE_BYPASS_EN.
